// File: rtl/alu_seq_pkg.sv
// Shared types and encodings for the ALU op sequencer: opcode enum, the ALU
// block's output/load/argument codes, and the packed control word.
// Optional feature macro used by the design: ALU_SEQ_SHN_EN (multi-step SHN).
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_MOV = 4'h1, OP_ADD = 4'h2, OP_ADC = 4'h3,
        OP_SUB = 4'h4, OP_SBC = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7,
        OP_XOR = 4'h8, OP_NOT = 4'h9, OP_SHF = 4'hA, OP_RCF = 4'hB,
        OP_SWP = 4'hC, OP_CMP = 4'hD, OP_SHN = 4'hE, OP_LDF = 4'hF
    } opcode_e;

    // Register bus-output codes
    localparam logic [3:0] OUT_A = 4'd0;
    localparam logic [3:0] OUT_B = 4'd1;
    localparam logic [3:0] OUT_C = 4'd8;
    localparam logic [3:0] OUT_D = 4'd9;

    // Functional-unit bus-output codes
    localparam logic [3:0] OUT_ADDSUB = 4'd2;
    localparam logic [3:0] OUT_FLAGS  = 4'd4;
    localparam logic [3:0] OUT_ANDOR  = 4'd6;
    localparam logic [3:0] OUT_SHSW   = 4'd7;
    localparam logic [3:0] OUT_XORNOT = 4'd10;
    localparam logic [3:0] OUT_NONE   = 4'd15;

    // Bus-load codes
    localparam logic [3:0] LOAD_A     = 4'd0;
    localparam logic [3:0] LOAD_B     = 4'd1;
    localparam logic [3:0] LOAD_C     = 4'd8;
    localparam logic [3:0] LOAD_D     = 4'd9;
    localparam logic [3:0] LOAD_FLAGS = 4'd7;
    localparam logic [3:0] LOAD_NONE  = 4'd15;

    localparam logic [2:0] ARG_R_NONE = 3'd7;

    typedef struct packed {
        logic [3:0] outctl;
        logic [3:0] loadctl;
        logic [1:0] arg_l;
        logic [2:0] arg_r;
        logic       alt;
        logic       calcfn;
        logic       cin;
    } ctl_word_t;

    localparam ctl_word_t IDLE_WORD = '{
        outctl:  OUT_NONE,
        loadctl: LOAD_NONE,
        arg_l:   2'd0,
        arg_r:   ARG_R_NONE,
        alt:     1'b0,
        calcfn:  1'b1,
        cin:     1'b0
    };

    // Register field (0=A..3=D) to its bus-output code
    function automatic logic [3:0] reg_out_code(input logic [1:0] r);
        logic [3:0] code;
        case (r)
            2'd0:    code = OUT_A;
            2'd1:    code = OUT_B;
            2'd2:    code = OUT_C;
            default: code = OUT_D;
        endcase
        return code;
    endfunction

    // Register field (0=A..3=D) to its bus-load code
    function automatic logic [3:0] reg_load_code(input logic [1:0] r);
        logic [3:0] code;
        case (r)
            2'd0:    code = LOAD_A;
            2'd1:    code = LOAD_B;
            2'd2:    code = LOAD_C;
            default: code = LOAD_D;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational instruction decoder: packed 8-bit op -> ALU control word.
// use_carry marks ops whose cin follows the live carry flag; multi marks SHN.
// Optional feature macro: ALU_SEQ_SHN_EN (opcode E is SHN, else NOP).
module alu_op_decode
    import alu_seq_pkg::*;
(
    input  logic [7:0] op,
    output ctl_word_t  word,
    output logic       use_carry,
    output logic       multi
);

    opcode_e    opc;
    logic [1:0] l_reg;
    logic [1:0] r_reg;

    assign opc   = opcode_e'(op[7:4]);
    assign l_reg = op[3:2];
    assign r_reg = op[1:0];

    // Start from the common "L op R -> L" word and override per opcode
    always_comb begin
        word         = '{outctl:  OUT_NONE,
                         loadctl: reg_load_code(l_reg),
                         arg_l:   l_reg,
                         arg_r:   {1'b0, r_reg},
                         alt:     1'b0,
                         calcfn:  1'b0,
                         cin:     1'b0};
        use_carry = 1'b0;
        multi     = 1'b0;
        case (opc)
            OP_NOP: word = IDLE_WORD;
            OP_MOV: begin
                word.outctl = reg_out_code(r_reg);
                word.arg_l  = 2'd0;
                word.arg_r  = ARG_R_NONE;
                word.calcfn = 1'b1;
            end
            OP_ADD: word.outctl = OUT_ADDSUB;
            OP_ADC: begin
                word.outctl = OUT_ADDSUB;
                use_carry   = 1'b1;
            end
            OP_SUB: begin
                word.outctl = OUT_ADDSUB;
                word.alt    = 1'b1;
                word.cin    = 1'b1;
            end
            OP_SBC: begin
                word.outctl = OUT_ADDSUB;
                word.alt    = 1'b1;
                use_carry   = 1'b1;
            end
            OP_AND: word.outctl = OUT_ANDOR;
            OP_OR: begin
                word.outctl = OUT_ANDOR;
                word.alt    = 1'b1;
            end
            OP_XOR: word.outctl = OUT_XORNOT;
            OP_NOT: begin
                word.outctl = OUT_XORNOT;
                word.alt    = 1'b1;
                word.arg_r  = ARG_R_NONE;
            end
            OP_SHF: begin
                word.outctl = OUT_SHSW;
                word.arg_r  = ARG_R_NONE;
            end
            OP_RCF: begin
                word.outctl = OUT_SHSW;
                word.arg_r  = ARG_R_NONE;
                use_carry   = 1'b1;
            end
            OP_SWP: begin
                word.outctl = OUT_SHSW;
                word.alt    = 1'b1;
                word.arg_r  = ARG_R_NONE;
            end
            OP_CMP: begin
                word.outctl  = OUT_ADDSUB;
                word.alt     = 1'b1;
                word.cin     = 1'b1;
                word.loadctl = LOAD_NONE;
            end
`ifdef ALU_SEQ_SHN_EN
            OP_SHN: begin
                word.outctl = OUT_SHSW;
                word.arg_r  = ARG_R_NONE;
                multi       = 1'b1;
            end
`else
            OP_SHN: word = IDLE_WORD;
`endif
            OP_LDF: begin
                word.outctl = OUT_FLAGS;
                word.arg_l  = 2'd0;
                word.arg_r  = ARG_R_NONE;
                word.calcfn = 1'b1;
            end
            default: word = IDLE_WORD;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU op sequencer top: accepts one instruction per valid/ready handshake and
// holds the decoded control word on the ALU block's control inputs for one
// EXEC cycle (or R+1 cycles for SHN). cin follows the live carry flag for
// carry-consuming ops so back-to-back carry chains see the freshly committed flag.
// Optional feature macro: ALU_SEQ_SHN_EN (multi-step SHN with step counter).
module alu_op_sequencer
    import alu_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] op,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [3:0] fout,
    output logic [3:0] outctl,
    output logic [3:0] loadctl,
    output logic [1:0] arg_l,
    output logic [2:0] arg_r,
    output logic       alt,
    output logic       calcfn,
    output logic       cin,
    output logic       busy,
    output logic       done
);

    typedef enum logic {S_IDLE, S_EXEC} state_e;

    state_e    state_q, state_d;
    ctl_word_t word_q, word_d;
    logic      use_carry_q, use_carry_d;

    ctl_word_t dec_word;
    logic      dec_use_carry;
    logic      dec_multi;
    logic      accept;
    logic      last_step;

    alu_op_decode u_decode (
        .op        (op),
        .word      (dec_word),
        .use_carry (dec_use_carry),
        .multi     (dec_multi)
    );

`ifdef ALU_SEQ_SHN_EN
    logic [1:0] steps_q, steps_d;

    assign last_step = (steps_q == 2'd0);

    // Remaining-step counter: loaded with R for SHN on accept, counts down in EXEC
    always_comb begin
        steps_d = steps_q;
        if (accept) begin
            steps_d = dec_multi ? op[1:0] : 2'd0;
        end else if (state_q == S_EXEC && !last_step) begin
            steps_d = steps_q - 2'd1;
        end
    end

    // Step counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) steps_q <= 2'd0;
        else     steps_q <= steps_d;
    end
`else
    logic unused_multi;
    assign unused_multi = dec_multi;
    assign last_step    = 1'b1;
`endif

    logic [2:0] unused_fout;
    assign unused_fout = fout[3:1];

    assign op_ready = (state_q == S_IDLE) || last_step;
    assign accept   = op_valid && op_ready;

    // Next state and next control word; a transfer in the final EXEC cycle
    // chains straight into the next EXEC without an idle gap
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        use_carry_d = use_carry_q;
        if (accept) begin
            state_d     = S_EXEC;
            word_d      = dec_word;
            use_carry_d = dec_use_carry;
        end else if (state_q == S_EXEC && last_step) begin
            state_d     = S_IDLE;
            word_d      = IDLE_WORD;
            use_carry_d = 1'b0;
        end
    end

    // State and registered control word; reset forces the idle word at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            word_q      <= IDLE_WORD;
            use_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            use_carry_q <= use_carry_d;
        end
    end

    assign outctl  = word_q.outctl;
    assign loadctl = word_q.loadctl;
    assign arg_l   = word_q.arg_l;
    assign arg_r   = word_q.arg_r;
    assign alt     = word_q.alt;
    assign calcfn  = word_q.calcfn;
    assign cin     = use_carry_q ? fout[0] : word_q.cin;
    assign busy    = (state_q == S_EXEC);
    assign done    = busy && last_step;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a decode table applied one instruction
// at a time, then hand-written back-to-back, SHN and reset sequences.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] op;
    logic       op_valid;
    logic       op_ready;
    logic [3:0] fout;
    logic [3:0] outctl;
    logic [3:0] loadctl;
    logic [1:0] arg_l;
    logic [2:0] arg_r;
    logic       alt;
    logic       calcfn;
    logic       cin;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .op       (op),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .fout     (fout),
        .outctl   (outctl),
        .loadctl  (loadctl),
        .arg_l    (arg_l),
        .arg_r    (arg_r),
        .alt      (alt),
        .calcfn   (calcfn),
        .cin      (cin),
        .busy     (busy),
        .done     (done)
    );

    typedef struct {
        logic [7:0] op;
        logic       f0;
        int         outctl;
        int         loadctl;
        int         arg_l;
        int         arg_r;
        int         alt;
        int         calcfn;
        int         cin;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    task automatic chk(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic chk_word(input string tag, input int oc, input int lc, input int al,
                            input int ar, input int a, input int cf, input int ci);
        chk({tag, ".outctl"},  int'(outctl),  oc);
        chk({tag, ".loadctl"}, int'(loadctl), lc);
        chk({tag, ".arg_l"},   int'(arg_l),   al);
        chk({tag, ".arg_r"},   int'(arg_r),   ar);
        chk({tag, ".alt"},     int'(alt),     a);
        chk({tag, ".calcfn"},  int'(calcfn),  cf);
        chk({tag, ".cin"},     int'(cin),     ci);
    endtask

    task automatic chk_status(input string tag, input int b, input int d, input int r);
        chk({tag, ".busy"},     int'(busy),     b);
        chk({tag, ".done"},     int'(done),     d);
        chk({tag, ".op_ready"}, int'(op_ready), r);
    endtask

    task automatic chk_idle(input string tag);
        chk_word(tag, 15, 15, 0, 7, 0, 1, 0);
        chk_status(tag, 0, 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            op     f0    oc  lc  al  ar alt cf cin
        vecs[0]  = '{8'h26, 1'b0,  2,  1,  1,  2,  0, 0, 0};  // ADD B,C
        vecs[1]  = '{8'h2F, 1'b1,  2,  9,  3,  3,  0, 0, 0};  // ADD D,D ignores carry
        vecs[2]  = '{8'h34, 1'b1,  2,  1,  1,  0,  0, 0, 1};  // ADC B,A carry=1
        vecs[3]  = '{8'h34, 1'b0,  2,  1,  1,  0,  0, 0, 0};  // ADC B,A carry=0
        vecs[4]  = '{8'h4B, 1'b0,  2,  8,  2,  3,  1, 0, 1};  // SUB C,D
        vecs[5]  = '{8'h5C, 1'b1,  2,  9,  3,  0,  1, 0, 1};  // SBC D,A carry=1
        vecs[6]  = '{8'h5C, 1'b0,  2,  9,  3,  0,  1, 0, 0};  // SBC D,A carry=0
        vecs[7]  = '{8'h61, 1'b0,  6,  0,  0,  1,  0, 0, 0};  // AND A,B
        vecs[8]  = '{8'h79, 1'b0,  6,  8,  2,  1,  1, 0, 0};  // OR C,B
        vecs[9]  = '{8'h82, 1'b0, 10,  0,  0,  2,  0, 0, 0};  // XOR A,C
        vecs[10] = '{8'h97, 1'b0, 10,  1,  1,  7,  1, 0, 0};  // NOT B
        vecs[11] = '{8'hA4, 1'b0,  7,  1,  1,  7,  0, 0, 0};  // SHF B
        vecs[12] = '{8'hBB, 1'b1,  7,  8,  2,  7,  0, 0, 1};  // RCF C carry=1
        vecs[13] = '{8'hCC, 1'b0,  7,  9,  3,  7,  1, 0, 0};  // SWP D
        vecs[14] = '{8'hD4, 1'b0,  2, 15,  1,  0,  1, 0, 1};  // CMP B,A
        vecs[15] = '{8'h1E, 1'b0,  8,  9,  0,  7,  0, 1, 0};  // MOV D,C
        vecs[16] = '{8'hF8, 1'b0,  4,  8,  0,  7,  0, 1, 0};  // LDF C
        vecs[17] = '{8'h00, 1'b0, 15, 15,  0,  7,  0, 1, 0};  // NOP

        rst = 1'b1; op = 8'h00; op_valid = 1'b0; fout = 4'h0;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_idle("post_reset");

        // Decode table: one instruction, one EXEC cycle, then back to idle
        for (int i = 0; i < NVEC; i++) begin
            op = vecs[i].op; fout = {3'b000, vecs[i].f0}; op_valid = 1'b1;
            @(negedge clk);
            op_valid = 1'b0;
            chk_word($sformatf("vec%0d", i), vecs[i].outctl, vecs[i].loadctl, vecs[i].arg_l,
                     vecs[i].arg_r, vecs[i].alt, vecs[i].calcfn, vecs[i].cin);
            chk_status($sformatf("vec%0d", i), 1, 1, 1);
            $display("txn op=%02h outctl=%0d loadctl=%0d cin=%0d", vecs[i].op, outctl, loadctl, cin);
            @(negedge clk);
            chk($sformatf("vec%0d.after_busy", i), int'(busy), 0);
            chk($sformatf("vec%0d.after_outctl", i), int'(outctl), 15);
        end

        // Back-to-back ADD B,C then ADC A,A; carry rises after the ADD commit
        fout = 4'h0; op = 8'h26; op_valid = 1'b1;
        @(negedge clk);
        chk_word("b2b_add", 2, 1, 1, 2, 0, 0, 0);
        chk_status("b2b_add", 1, 1, 1);
        op = 8'h30;
        @(posedge clk);
        #1 fout = 4'h1;
        @(negedge clk);
        op_valid = 1'b0;
        chk_word("b2b_adc", 2, 0, 0, 0, 0, 0, 1);
        chk_status("b2b_adc", 1, 1, 1);
        $display("txn op=26,30 back-to-back cin=%0d", cin);
        @(negedge clk);
        chk("b2b_end.busy", int'(busy), 0);
        fout = 4'h0;

`ifdef ALU_SEQ_SHN_EN
        // SHN B,4 with LDF C presented (valid held) during the non-final cycles
        op = 8'hE7; op_valid = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk_word($sformatf("shn_c%0d", c), 7, 1, 1, 7, 0, 0, 0);
            chk_status($sformatf("shn_c%0d", c), 1, (c == 4) ? 1 : 0, (c == 4) ? 1 : 0);
            if (c == 1) op = 8'hF8;
        end
        $display("txn op=E7 shn 4 cycles");
`else
        // Without the SHN option opcode E is a one-cycle NOP
        op = 8'hE7; op_valid = 1'b1;
        @(negedge clk);
        chk_word("shn_nop", 15, 15, 0, 7, 0, 1, 0);
        chk_status("shn_nop", 1, 1, 1);
        op = 8'hF8;
        $display("txn op=E7 nop");
`endif
        @(negedge clk);
        op_valid = 1'b0;
        chk_word("queued_ldf", 4, 8, 0, 7, 0, 1, 0);
        chk_status("queued_ldf", 1, 1, 1);
        $display("txn op=F8 after pending");
        @(negedge clk);
        chk("queued_end.busy", int'(busy), 0);

        // Reset in the middle of execution forces the idle word immediately
`ifdef ALU_SEQ_SHN_EN
        op = 8'hE7; op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        chk_status("rst_shn_c1", 1, 0, 0);
        @(negedge clk);
        chk_status("rst_shn_c2", 1, 0, 0);
`else
        op = 8'h26; op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        chk_status("rst_exec", 1, 1, 1);
`endif
        rst = 1'b1;
        #1;
        chk_idle("mid_rst");
        @(negedge clk);
        rst = 1'b0; op = 8'hF8; op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        chk_word("rst_ldf", 4, 8, 0, 7, 0, 1, 0);
        chk_status("rst_ldf", 1, 1, 1);
        $display("txn op=F8 after reset");
        @(negedge clk);
        chk_idle("final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
